muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU); sits beside the EX-stage ALU.
- Accepts one operation per start pulse, runs a radix-2 shift-add or restoring-divide loop over XLEN cycles, and returns a registered result with a one-cycle done pulse.
- busy drives the hazard logic that stalls IF/ID/EX; flush aborts an in-flight operation on redirect.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when ready=1.
- funct3  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src_a  in  XLEN  rs1 operand.
- src_b  in  XLEN  rs2 operand.
- flush  in  1  abort current operation.
- ready  out  1  high in IDLE or DONE; start is accepted this cycle.
- busy  out  1  high in CALC.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  registered result; holds until the next completion.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, busy=0, done=0, result=0, counter=0. Reset overrides start and flush.
- States and transitions:
  - IDLE: start=1 → load operands, op, and sign flags. Fast case → DONE; otherwise → CALC with cnt=XLEN-1.
  - CALC: one iteration per edge, cnt decrements. At the edge where cnt==0, apply final sign fixup, write result, → DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back ops); otherwise → IDLE.
- Latency, with start sampled at edge k:
  - Normal op: done high in the cycle after edge k+XLEN, i.e. 32 iterations.
  - Fast case: done high in the cycle after edge k.
- Signed handling:
  - Operands are converted to magnitude per op signedness (MULHSU: src_a signed, src_b unsigned), and the loop runs unsigned.
  - Product negated if the operand signs differ.
  - Quotient sign = sa^sb; remainder sign = sa.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- Fast cases (no CALC):
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = src_a.
  - Signed overflow, DIV 0x80000000 / -1: result = 0x80000000; REM result = 0.
  - Multiply by zero is not a fast case.
- Flush:
  - flush=1 at an edge with state CALC or DONE → IDLE; no done for the aborted op; result keeps its previous value.
  - flush and start in the same cycle: flush wins and start is dropped.
- start while busy=1 is ignored; the upstream stage holds it under stall.
- Operands and funct3 are captured at acceptance; later changes on src_a, src_b or funct3 have no effect.
- result changes only on the edge entering DONE.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN product and take the fast path (IDLE→DONE, done one cycle after acceptance).
  - DIV/REM ops are unchanged.
- Not defined: all multiplies take the iterative 32-cycle path.

Test Plan:
- Reset mid-CALC: rst during iteration 10 → next cycle busy=0, done=0, result=0, ready=1; no done pulse afterwards.
- MUL with 7 and 0xFFFFFFFD (-3) → done at cycle k+33 (k+1 with MULDIV_FAST_MUL_EN), result=0xFFFFFFEB. Then back-to-back MULHU with 0xFFFFFFFF and 0xFFFFFFFF, started in the DONE cycle → result=0xFFFFFFFE. Also MULH with 0x80000000 and 0x80000000 → 0x40000000; MULHSU with 0xFFFFFFFF and 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2. Each takes 32 busy cycles.
- Fast cases, each done one cycle after start with busy never high:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- Flush:
  - flush at iteration 20 of DIV → IDLE next cycle, no done pulse, result unchanged from the prior op.
  - flush and start in the same cycle → start dropped, state stays IDLE.
- start pulsed while busy with different operands → ignored; the original op's result is returned at the expected cycle.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer beside the EX ALU.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplies.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] dvs;

  logic            accept;
  logic            sgn_a;
  logic            sgn_b;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic            fast_mul;
  logic            fast;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rsh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] hi_n;
  logic [XLEN-1:0] lo_n;
  logic [XLEN-1:0] calc_res;

  // Sign fixup and result selection from the unsigned hi/lo pair.
  function automatic logic [XLEN-1:0] fixup(
    input logic [2:0]      f,
    input logic            nq,
    input logic            nr,
    input logic [XLEN-1:0] h,
    input logic [XLEN-1:0] l
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q;
    logic [XLEN-1:0]   r;
    p = {h, l};
    if (nq) p = -p;
    q = nq ? -l : l;
    r = nr ? -h : h;
    if (f[2])
      fixup = f[1] ? r : q;
    else if (f == 3'b000)
      fixup = p[XLEN-1:0];
    else
      fixup = p[2*XLEN-1:XLEN];
  endfunction

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

  assign accept = ready && start && !flush;

  assign sgn_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sgn_b = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                 (funct3 == 3'b110);
  assign sa    = sgn_a && src_a[XLEN-1];
  assign sb    = sgn_b && src_b[XLEN-1];
  assign mag_a = sa ? -src_a : src_a;
  assign mag_b = sb ? -src_b : src_b;

  assign div_zero = funct3[2] && (src_b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] &&
                    (src_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (&src_b);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_full;
  assign prod_full = mag_a * mag_b;
  assign fast_mul  = !funct3[2];
  assign mul_res   = fixup(funct3, sa ^ sb, sa,
                           prod_full[2*XLEN-1:XLEN],
                           prod_full[XLEN-1:0]);
`else
  assign fast_mul = 1'b0;
  assign mul_res  = '0;
`endif

  assign fast = div_zero || div_ovf || fast_mul;

  // Result for ops that skip the iterative loop.
  always_comb begin
    fast_res = mul_res;
    if (div_zero)
      fast_res = funct3[1] ? src_a : '1;
    else if (div_ovf)
      fast_res = funct3[1] ? '0 : src_a;
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    rsh     = {hi, lo[XLEN-1]};
    diff    = rsh - {1'b0, dvs};
    ge      = !diff[XLEN];
    if (op[2]) begin
      hi_n = ge ? diff[XLEN-1:0] : rsh[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ge};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
    calc_res = fixup(op, neg_q, neg_r, hi_n, lo_n);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; flush aborts, DONE may chain a new op.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_n = fast ? DONE : CALC;
        else        state_n = IDLE;
      end
      CALC: begin
        if (flush)          state_n = IDLE;
        else if (cnt == '0) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, iteration registers and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      result <= '0;
    end else if (accept) begin
      op    <= funct3;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      hi    <= '0;
      lo    <= mag_a;
      dvs   <= mag_b;
      cnt   <= CW'(XLEN - 1);
      if (fast) result <= fast_res;
    end else if (state == CALC && !flush) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) result <= calc_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq.
// Checks results, latency, busy cycles, flush and reset.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int L_MUL = 1;
`else
  localparam int L_MUL = 33;
`endif
  localparam int L_DIV = 33;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b);
    funct3 = f;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    src_a  = 32'h1234_5678;
    src_b  = 32'h0000_0003;
    funct3 = 3'b111;
  endtask

  task automatic wait_done(input string tag,
                           input logic [31:0] exp,
                           input int lat,
                           input bit poke);
    int n = 0;
    int nb = 0;
    bit seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (poke && n == 5) begin
        funct3 = 3'b101;
        src_a  = 32'd9;
        src_b  = 32'd3;
        start  = 1'b1;
      end
      if (poke && n == 6) start = 1'b0;
      if (busy) nb++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, nb, lat - 1);
    chk({tag, "_res"}, result, exp);
  endtask

  task automatic watch_quiet(input string tag, input int cyc);
    int nd = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk(tag, nd, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    src_a  = '0;
    src_b  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 1);
    chk("rst_res", result, 0);

    issue(3'b101, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_res", result, 0);
    watch_quiet("mid_rst_quiet", 40);

    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul", 32'hFFFF_FFEB, L_MUL, 1'b0);
    chk("b2b_ready", ready, 1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu", 32'hFFFF_FFFE, L_MUL, 1'b0);
    @(negedge clk);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000);
    wait_done("mulh", 32'h4000_0000, L_MUL, 1'b0);
    @(negedge clk);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhsu", 32'hFFFF_FFFF, L_MUL, 1'b0);

    @(negedge clk);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 32'hFFFF_FFFD, L_DIV, 1'b0);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2);
    wait_done("rem", 32'hFFFF_FFFF, L_DIV, 1'b0);
    issue(3'b101, 32'd100, 32'd7);
    wait_done("divu", 32'd14, L_DIV, 1'b0);
    issue(3'b111, 32'd100, 32'd7);
    wait_done("remu", 32'd2, L_DIV, 1'b0);

    @(negedge clk);
    issue(3'b101, 32'd5, 32'd0);
    wait_done("divu_z", 32'hFFFF_FFFF, 1, 1'b0);
    issue(3'b110, 32'd5, 32'd0);
    wait_done("rem_z", 32'd5, 1, 1'b0);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'h8000_0000, 1, 1'b0);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("rem_ovf", 32'd0, 1, 1'b0);

    @(negedge clk);
    issue(3'b111, 32'd100, 32'd7);
    wait_done("remu2", 32'd2, L_DIV, 1'b0);
    @(negedge clk);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_ready", ready, 1);
    chk("flush_done", done, 0);
    watch_quiet("flush_quiet", 40);
    chk("flush_res", result, 32'd2);

    flush = 1'b1;
    issue(3'b101, 32'd5, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("fs_busy", busy, 0);
    chk("fs_done", done, 0);
    watch_quiet("fs_quiet", 40);
    chk("fs_res", result, 32'd2);

    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7);
    wait_done("poke", 32'd14, L_DIV, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
